// File: rtl/da_pkg.sv
// Shared defaults and the FSM state encoding for the distributed-arithmetic MAC slice.
// Holds no logic, so it adds no latency.
// Holds no handshake signals, so there is no backpressure here.
package da_pkg;

  // Default geometry: one LUT per group of DA_NTAP taps. The accumulator must
  // hold LUT_W + DATA_W bits so that the shifted sums can never overflow.
  localparam int DA_DATA_W = 16;
  localparam int DA_NTAP   = 8;
  localparam int DA_LUT_W  = 32;
  localparam int DA_ACC_W  = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } da_state_e;

  // Bit-slice counter width. The result is at least 1 so that a one-bit
  // sample width still has a legal counter.
  function automatic int da_cnt_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/da_addr_slicer.sv
// Builds the LUT address from bit bit_idx_i of each latched sample.
// This block is purely combinational, so it has zero latency.
// It has no handshake. Its output is forced to 0 whenever run_i is low.
//
// Ports:
//   samples_i  NTAP*DATA_W  sample i is at samples_i[i*DATA_W +: DATA_W]
//   bit_idx_i  CNT_W        current bit slice (LSB first)
//   run_i      1            high only while the engine is in RUN
//   lut_addr_o NTAP         bit i = samples_i[i][bit_idx_i], or 0 outside RUN
module da_addr_slicer
  import da_pkg::*;
#(
  parameter int DATA_W = DA_DATA_W,
  parameter int NTAP   = DA_NTAP,
  parameter int CNT_W  = da_cnt_w(DATA_W)
) (
  input  logic [NTAP*DATA_W-1:0] samples_i,
  input  logic [CNT_W-1:0]       bit_idx_i,
  input  logic                   run_i,
  output logic [NTAP-1:0]        lut_addr_o
);

  for (genvar i = 0; i < NTAP; i++) begin : g_tap
    logic [DATA_W-1:0] sample;
    assign sample = samples_i[i*DATA_W +: DATA_W];
    // Gating keeps the LUT address quiet outside RUN.
    assign lut_addr_o[i] = run_i & sample[bit_idx_i];
  end

endmodule

// File: rtl/da_slice_mac.sv
// Bit-serial distributed-arithmetic MAC. It reads one coefficient-sum LUT and
//   produces sum_i b_i*sample_i.
// Latency: out_valid rises exactly DATA_W edges after the accept edge. A new
//   group can start at most once every DATA_W+2 cycles.
// Backpressure: with out_ready low the engine holds DONE and out_data
//   indefinitely. in_ready is high only in IDLE.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    sample-group valid (in)
//   in_ready    engine is in IDLE and can accept a group (out)
//   in_data     NTAP samples; sample i is at in_data[i*DATA_W +: DATA_W] (in)
//   lut_addr    current bit slice of every sample (out)
//   lut_data    combinational LUT response to lut_addr (in)
//   out_valid   result valid (out)
//   out_ready   consumer accepts the result (in)
//   out_data    signed partial sum (out)
module da_slice_mac
  import da_pkg::*;
#(
  parameter int DATA_W = DA_DATA_W,
  parameter int NTAP   = DA_NTAP,
  parameter int LUT_W  = DA_LUT_W,
  parameter int ACC_W  = DA_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NTAP*DATA_W-1:0] in_data,
  output logic [NTAP-1:0]        lut_addr,
  input  logic [LUT_W-1:0]       lut_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data
);

  localparam int CNT_W = da_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Stop elaboration if the accumulator is too narrow to hold the result.
  if (ACC_W < LUT_W + DATA_W) begin : g_width_check
    $error("da_slice_mac: ACC_W must be at least LUT_W + DATA_W");
  end

  da_state_e               state_q, state_d;
  logic [NTAP*DATA_W-1:0]  samples_q, samples_d;
  logic [CNT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;

  logic [ACC_W-1:0]        lut_sext;
  logic [ACC_W-1:0]        slice_term;

  // The LUT value is sign-extended to the full accumulator width before it is
  // shifted. This keeps negative coefficient sums correct at every weight.
  assign lut_sext   = {{(ACC_W-LUT_W){lut_data[LUT_W-1]}}, lut_data};
  assign slice_term = lut_sext << bit_idx_q;

  da_addr_slicer #(
    .DATA_W (DATA_W),
    .NTAP   (NTAP),
    .CNT_W  (CNT_W)
  ) u_slicer (
    .samples_i  (samples_q),
    .bit_idx_i  (bit_idx_q),
    .run_i      (state_q == RUN),
    .lut_addr_o (lut_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      samples_q <= '0;
      bit_idx_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      samples_q <= samples_d;
      bit_idx_q <= bit_idx_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    samples_d = samples_q;
    bit_idx_d = bit_idx_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          samples_d = in_data;
          bit_idx_d = '0;
          acc_d     = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (bit_idx_q == LAST_BIT) begin
          // In two's complement the MSB carries negative weight, so the last
          // slice is subtracted.
          acc_d     = acc_q - slice_term;
          bit_idx_d = '0;
          state_d   = DONE;
        end else begin
          acc_d     = acc_q + slice_term;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // The engine returns to IDLE first and accepts a new group only on
        // the next cycle. A group offered during the handshake therefore waits.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // acc_q is held through DONE, so out_data stays stable under backpressure.
  assign out_data = acc_q;

endmodule
